// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, the ID/EX pipeline register and the forwarding sources.
// master drives decode/forwarding/control inputs; slave is the ID/EX stage itself.
interface id_ex_stage_if;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [31:0] rf_r1_data;
    logic [31:0] rf_r2_data;
    logic [4:0]  id_waddr;
    logic        id_we;
    logic        id_mem_read;
    logic [3:0]  id_alu_op;
    logic [31:0] id_imm;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        ex_hold;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [31:0] ex_imm;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_waddr;
    logic        ex_we;
    logic        ex_mem_read;
    logic        id_stall;

    modport master (
        output id_valid, id_rs, id_rt, rf_r1_data, rf_r2_data, id_waddr, id_we, id_mem_read,
               id_alu_op, id_imm, mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata,
               ex_hold, flush,
        input  ex_valid, ex_op_a, ex_op_b, ex_imm, ex_alu_op, ex_waddr, ex_we, ex_mem_read,
               id_stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, rf_r1_data, rf_r2_data, id_waddr, id_we, id_mem_read,
               id_alu_op, id_imm, mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata,
               ex_hold, flush,
        output ex_valid, ex_op_a, ex_op_b, ex_imm, ex_alu_op, ex_waddr, ex_we, ex_mem_read,
               id_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble insertion,
// downstream hold and flush.
module id_ex_stage (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);
    logic        valid_q, valid_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] imm_q, imm_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [4:0]  waddr_q, waddr_d;
    logic        we_q, we_d;
    logic        mem_read_q, mem_read_d;
    logic [31:0] fwd_a, fwd_b;
    logic        load_use;

    // MEM result is younger than WB, so it wins when both target the same register.
    function automatic logic [31:0] forward(input logic [4:0] src, input logic [31:0] rf_data,
                                            input logic m_we, input logic [4:0] m_addr,
                                            input logic [31:0] m_data, input logic w_we,
                                            input logic [4:0] w_addr, input logic [31:0] w_data);
        if (src == 5'd0)                     return 32'h0;
        else if (m_we && (m_addr == src))    return m_data;
        else if (w_we && (w_addr == src))    return w_data;
        else                                 return rf_data;
    endfunction

    always_comb begin
        fwd_a = forward(bus.id_rs, bus.rf_r1_data, bus.mem_we, bus.mem_waddr, bus.mem_wdata,
                        bus.wb_we, bus.wb_waddr, bus.wb_wdata);
        fwd_b = forward(bus.id_rt, bus.rf_r2_data, bus.mem_we, bus.mem_waddr, bus.mem_wdata,
                        bus.wb_we, bus.wb_waddr, bus.wb_wdata);
    end

    assign load_use = bus.id_valid && valid_q && mem_read_q && (waddr_q != 5'd0) &&
                      ((waddr_q == bus.id_rs) || (waddr_q == bus.id_rt));

    assign bus.id_stall = (load_use || bus.ex_hold) && !bus.flush;

    always_comb begin
        valid_d    = valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        imm_d      = imm_q;
        alu_op_d   = alu_op_q;
        waddr_d    = waddr_q;
        we_d       = we_q;
        mem_read_d = mem_read_q;
        if (bus.flush || (!bus.ex_hold && load_use)) begin
            // Kill or bubble: only the qualifying flags matter, data fields are left as-is.
            valid_d    = 1'b0;
            we_d       = 1'b0;
            mem_read_d = 1'b0;
        end else if (!bus.ex_hold) begin
            valid_d    = bus.id_valid;
            op_a_d     = fwd_a;
            op_b_d     = fwd_b;
            imm_d      = bus.id_imm;
            alu_op_d   = bus.id_alu_op;
            waddr_d    = bus.id_waddr;
            we_d       = bus.id_we && bus.id_valid;
            mem_read_d = bus.id_mem_read && bus.id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            op_a_q     <= 32'h0;
            op_b_q     <= 32'h0;
            imm_q      <= 32'h0;
            alu_op_q   <= 4'h0;
            waddr_q    <= 5'h0;
            we_q       <= 1'b0;
            mem_read_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            imm_q      <= imm_d;
            alu_op_q   <= alu_op_d;
            waddr_q    <= waddr_d;
            we_q       <= we_d;
            mem_read_q <= mem_read_d;
        end
    end

    assign bus.ex_valid    = valid_q;
    assign bus.ex_op_a     = op_a_q;
    assign bus.ex_op_b     = op_b_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_alu_op   = alu_op_q;
    assign bus.ex_waddr    = waddr_q;
    assign bus.ex_we       = we_q;
    assign bus.ex_mem_read = mem_read_q;
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters: none; all datapaths 32 bits, register addresses 5 bits.
REQ-002 clk  in  1  single clock, all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 id_valid  in  1  instruction present in decode.
REQ-005 id_rs, id_rt  in  5 each  source addresses, also driven to register-file read ports.
REQ-006 rf_r1_data, rf_r2_data  in  32 each  combinational register-file read data for id_rs, id_rt.
REQ-007 id_waddr  in  5; id_we  in  1; id_mem_read  in  1; id_alu_op  in  4; id_imm  in  32  decode control and immediate.
REQ-008 mem_we  in  1; mem_waddr  in  5; mem_wdata  in  32  MEM-stage result.
REQ-009 wb_we  in  1; wb_waddr  in  5; wb_wdata  in  32  WB-stage result, same values driven to register-file write port.
REQ-010 ex_hold  in  1  downstream not accepting; flush  in  1  kill decode and EX contents (branch/jump taken).
REQ-011 ex_valid  out  1; ex_op_a, ex_op_b  out  32; ex_imm  out  32; ex_alu_op  out  4; ex_waddr  out  5; ex_we  out  1; ex_mem_read  out  1  registered EX-stage bundle.
REQ-012 id_stall  out  1  combinational; when 1, PC and IF/ID register shall hold.

Function
REQ-013 Operand forwarding (combinational, per source, independently for rs and rt): if source address is 0, value is 32'h0; else if mem_we and mem_waddr equals source, mem_wdata; else if wb_we and wb_waddr equals source, wb_wdata; else register-file data.
REQ-014 MEM forwarding shall take priority over WB when both match.
REQ-015 Load-use hazard = id_valid and ex_valid and ex_mem_read and ex_waddr nonzero and (ex_waddr equals id_rs or ex_waddr equals id_rt).
REQ-016 id_stall = (load_use or ex_hold) and not flush.
REQ-017 Per-cycle register update priority: flush > ex_hold > load_use > normal load.
REQ-018 flush: ex_valid<=0, ex_we<=0, ex_mem_read<=0; other fields don't-care.
REQ-019 ex_hold (no flush): all outputs hold current values.
REQ-020 load_use (no flush, no hold): insert bubble -- ex_valid<=0, ex_we<=0, ex_mem_read<=0; decode instruction retained upstream and re-evaluated next cycle.
REQ-021 Normal load: ex_valid<=id_valid; ex_op_a/ex_op_b <= forwarded rs/rt values; ex_imm, ex_alu_op, ex_waddr copied; ex_we<=id_we and id_valid; ex_mem_read<=id_mem_read and id_valid.
REQ-022 Load-use stall lasts exactly one cycle when ex_hold is 0; after the bubble the operand is obtained through MEM forwarding.
REQ-023 During ex_hold, forwarded values are not captured; operands are re-forwarded on the cycle the hold releases.
REQ-024 ex_we shall never be 1 while ex_valid is 0.

Reset
REQ-025 On rst low, immediately: ex_valid=0, ex_we=0, ex_mem_read=0, ex_op_a=ex_op_b=ex_imm=32'h0, ex_alu_op=4'h0, ex_waddr=5'h0; id_stall follows its combinational definition from reset-state registers (0 unless ex_hold).
REQ-026 Reset asserted mid-stall or mid-hold shall discard the in-flight EX contents; first posedge after release performs a normal load.

Verification
REQ-027 id_rs=3, rf_r1_data=5, mem_we=1 mem_waddr=3 mem_wdata=9, wb_we=1 wb_waddr=3 wb_wdata=7 -> next cycle ex_op_a=9.
REQ-028 id_rt=0, mem_we=1 mem_waddr=0 mem_wdata=32'hFFFF_FFFF -> ex_op_b=0.
REQ-029 ex holds load with ex_waddr=4, ex_mem_read=1; decode id_rs=4 -> id_stall=1 one cycle, next ex_valid=0, then with mem_waddr=4 mem_wdata=32'hAB, ex_op_a=32'hAB, ex_valid=1.
REQ-030 flush=1 together with load_use and ex_hold=1 -> id_stall=0, next cycle ex_valid=0, ex_we=0.
REQ-031 ex_hold=1 for 3 cycles with changing decode inputs -> all ex_* outputs constant, id_stall=1 throughout.
REQ-032 rst driven low between clock edges with ex_valid=1 -> ex_valid, ex_we, ex_op_a go 0 before next posedge.
